prm_oblgc_scan: RTL
===================

PRM_OBLGC_SCAN -- requirements
Module: prm_oblgc_scan

Interface
REQ-001 SHALL have parameter NUM_EDGE, default 32: width of the edge-mask bus returned by the checker bank.
REQ-002 SHALL have parameter DEPTH, default 16: voxel FIFO entries, power of two, minimum 2.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-005 SHALL have port vox_valid  in  1: voxel code offered.
REQ-006 SHALL have port vox_ready  out  1: FIFO can accept.
REQ-007 SHALL have port vox_code  in  15: obstacle voxel code; bit0=A ... bit14=O.
REQ-008 SHALL have port vox_last  in  1: final voxel of the current obstacle set.
REQ-009 SHALL have port chk_code  out  15: registered code driven to the inputs A..O of every checker in the bank.
REQ-010 SHALL have port chk_mask  in  NUM_EDGE: the combined edge_mask outputs of the checker bank, combinational from chk_code.
REQ-011 SHALL have port res_valid  out  1: result available.
REQ-012 SHALL have port res_ready  in  1: result consumer ready.
REQ-013 SHALL have port res_mask  out  NUM_EDGE: OR of chk_mask over every voxel in the set; bit set = edge blocked.
REQ-014 SHALL have port res_count  out  16: number of voxels in the set, saturating.
REQ-015 SHALL have port busy  out  1: high whenever state is not IDLE or the FIFO is non-empty.

Function
REQ-016 SHALL store {vox_last, vox_code} in the FIFO when vox_valid && vox_ready; vox_ready = !full, independent of FSM state.
REQ-017 SHALL implement FSM states IDLE, SCAN, DRAIN and REPORT.
REQ-018 IDLE SHALL go to SCAN when the FIFO is non-empty.
REQ-019 SCAN SHALL pop one entry per cycle while the FIFO is non-empty, load chk_code with its code, and set pend=1 for one cycle; with the FIFO empty, no pop occurs, chk_code holds and pend=0.
REQ-020 SHALL OR chk_mask into acc, and increment cnt (saturating at 0xFFFF), in the cycle after each pop (pend=1); latency from pop to accumulation is exactly 1 cycle.
REQ-021 SCAN SHALL go to DRAIN on popping an entry with last=1, and SHALL NOT pop in DRAIN.
REQ-022 DRAIN SHALL accumulate the final sample, then go to REPORT next cycle.
REQ-023 REPORT SHALL assert res_valid with res_mask=acc and res_count=cnt, all stable until res_ready.
REQ-024 On res_valid && res_ready, SHALL clear acc and cnt and go to IDLE.
REQ-025 res_valid SHALL NOT depend combinationally on res_ready.
REQ-026 Push on a full FIFO SHALL NOT occur (vox_ready=0); push and pop in the same cycle SHALL both take effect when the FIFO is not full.
REQ-027 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from an extra pointer bit or an occupancy counter.
REQ-028 Voxels arriving during DRAIN or REPORT SHALL remain queued and belong to the next set.
REQ-029 A set with vox_last on its first voxel SHALL report res_count=1.

Reset
REQ-030 While rst=1 the FSM SHALL go to IDLE, the FIFO SHALL empty, acc=0, cnt=0, pend=0.
REQ-031 During rst=1 the outputs SHALL be: chk_code=0, res_valid=0, res_mask=0, res_count=0, busy=0, vox_ready=0.
REQ-032 On the cycle after rst deasserts, vox_ready=1.
REQ-033 Reset asserted mid-set SHALL discard all partial results without emitting a result.

Verification
REQ-034 Single voxel 0x4000 with last=1, checker model returns mask 0x5 -> res_valid 4 cycles after push, res_mask=0x5, res_count=1.
REQ-035 Three back-to-back voxels with masks 0x1, 0x100, 0x1, last on the third -> res_mask=0x101, res_count=3; chk_code shows one code per consecutive cycle.
REQ-036 Hold res_ready=0 for 10 cycles while pushing DEPTH further voxels -> result held stable, vox_ready=0 once full, no entry lost; second set reported correctly after release.
REQ-037 Assert rst after 2 voxels of a 5-voxel set -> no res_valid; all outputs 0; a following new set reports only its own voxels.
REQ-038 Random voxel streams with random vox_valid/res_ready backpressure, compared against a reference OR model -> exact match of every res_mask and res_count; 70000 voxels in one set -> res_count=0xFFFF.

Source files
------------

// File: rtl/prm_oblgc_scan.sv
// Obstacle-voxel scanner: queues voxel codes, drives them one per cycle into an external
// edge-checker bank and ORs the returned edge masks into one blocked-edge result per set.
module prm_oblgc_scan #(
  parameter int unsigned NUM_EDGE = 32,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vox_valid,
  output logic                vox_ready,
  input  logic [14:0]         vox_code,
  input  logic                vox_last,
  output logic [14:0]         chk_code,
  input  logic [NUM_EDGE-1:0] chk_mask,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NUM_EDGE-1:0] res_mask,
  output logic [15:0]         res_count,
  output logic                busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;

  logic [1:0]          state;
  logic [15:0]         mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic [15:0]         rd_entry;
  logic                pend;
  logic [NUM_EDGE-1:0] acc;
  logic [15:0]         cnt;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push     = vox_valid && vox_ready;
  assign pop      = (state == SCAN) && !empty;
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  assign vox_ready = !rst && !full;
  assign res_valid = !rst && (state == REPORT);
  assign busy      = !rst && ((state != IDLE) || !empty);
  assign res_mask  = acc;
  assign res_count = cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {vox_last, vox_code};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      chk_code <= '0;
      pend     <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      pend <= pop;
      if (pop) begin
        chk_code <= rd_entry[14:0];
      end
      // The checker bank answers combinationally, so each popped code is folded in one cycle later.
      if (pend) begin
        acc <= acc | chk_mask;
        if (cnt != 16'hFFFF) begin
          cnt <= cnt + 16'd1;
        end
      end
      case (state)
        IDLE: begin
          if (!empty) begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (pop && rd_entry[15]) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= REPORT;
        end
        REPORT: begin
          if (res_ready) begin
            acc   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
